// File: rtl/button_pkg.sv
// Shared constants for the active-low push-button conditioning path.
package button_pkg;

    localparam logic BTN_RELEASED = 1'b1;
    localparam logic BTN_PRESSED  = 1'b0;

    localparam int N_BTN_DEFAULT           = 4;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;  // 1 ms at 50 MHz
    localparam int DEBOUNCE_CYCLES_SIM     = 4;

endpackage

// File: rtl/button_debounce_if.sv
// Button bundle: raw pins in, debounced level/pulses/toggle out. The debouncer sits on the slave side.
interface button_debounce_if
    import button_pkg::*;
#(
    parameter int N_BTN = N_BTN_DEFAULT
);

    logic [N_BTN-1:0] i_btn_n;
    logic [N_BTN-1:0] o_btn_n;
    logic [N_BTN-1:0] o_press;
    logic [N_BTN-1:0] o_release;
    logic [N_BTN-1:0] o_toggle;

    modport master (
        output i_btn_n,
        input  o_btn_n,
        input  o_press,
        input  o_release,
        input  o_toggle
    );

    modport slave (
        input  i_btn_n,
        output o_btn_n,
        output o_press,
        output o_release,
        output o_toggle
    );

endinterface

// File: rtl/button_debounce_ch.sv
// One button channel: 2-flop synchroniser, stability counter, debounced level and press/release pulses.
// The toggle flop exists only when BUTTON_DEBOUNCE_TOGGLE_EN is defined; otherwise o_toggle is tied low.
module button_debounce_ch
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn_n,
    output logic o_btn_n,
    output logic o_press,
    output logic o_release,
    output logic o_toggle
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q,  stable_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             press_q,   press_d;
    logic             release_q, release_d;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch can leave one unassigned and infer a latch.
        stable_d  = stable_q;
        cnt_d     = '0;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d  = sync2_q;
                press_d   = (sync2_q == BTN_PRESSED);
                release_d = (sync2_q == BTN_RELEASED);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: non-blocking assignments make every flop sample pre-edge values, which is what keeps sync1 -> sync2 two real stages.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q   <= BTN_RELEASED;
            sync2_q   <= BTN_RELEASED;
            stable_q  <= BTN_RELEASED;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= i_btn_n;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign o_btn_n   = stable_q;
    assign o_press   = press_q;
    assign o_release = release_q;

`ifdef BUTTON_DEBOUNCE_TOGGLE_EN
    logic toggle_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            toggle_q <= 1'b0;
        end else begin
            toggle_q <= toggle_q ^ press_d;
        end
    end

    assign o_toggle = toggle_q;
`else
    assign o_toggle = 1'b0;
`endif

endmodule

// File: rtl/button_debounce.sv
// button_debounce: N_BTN independent debounce channels for the board's active-low push-buttons.
// Define BUTTON_DEBOUNCE_TOGGLE_EN to build the per-channel toggle state driving o_toggle.
module button_debounce
    import button_pkg::*;
#(
    parameter int N_BTN           = N_BTN_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input logic               i_clk,
    input logic               i_rst_n,
    button_debounce_if.slave  btn
);

    logic [N_BTN-1:0] level;
    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] rls;
    logic [N_BTN-1:0] toggle;

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        button_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_btn_n   (btn.i_btn_n[g]),
            .o_btn_n   (level[g]),
            .o_press   (press[g]),
            .o_release (rls[g]),
            .o_toggle  (toggle[g])
        );
    end

    assign btn.o_btn_n   = level;
    assign btn.o_press   = press;
    assign btn.o_release = rls;
    assign btn.o_toggle  = toggle;

endmodule
